// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: multi-cycle add/sub/mul/div sequencer with double-dabble BCD conversion
module calc_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] mode,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] op,
    output logic       neg,
    output logic       err,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3
);
    typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;
    state_t      state;
    logic [3:0]  ra, rb, rm;
    logic [7:0]  acc, res, mul_nx, div_nx, exec_res;
    logic [4:0]  div_t;
    logic [19:0] sr, sr_nx;
    logic [2:0]  cnt;
    logic        neg_r, err_r, bad, exec_last;
    // reject non-one-hot modes and division by zero at capture time
    always_comb bad = (mode == 4'd0) || ((mode & (mode - 4'd1)) != 4'd0) || (mode[3] && b == 4'd0);
    // one shift-add step, one restoring-division step (acc = {remainder, dividend/quotient}), and the step result
    always_comb begin
        mul_nx    = acc + (rb[cnt[1:0]] ? ({4'd0, ra} << cnt[1:0]) : 8'd0);
        div_t     = {acc[7:4], acc[3]};
        div_nx    = (div_t >= {1'b0, rb}) ? {div_t[3:0] - rb, acc[2:0], 1'b1} : {div_t[3:0], acc[2:0], 1'b0};
        exec_last = rm[0] || rm[1] || cnt == 3'd3;
        exec_res  = rm[0] ? {4'd0, ra} + {4'd0, rb} :
                    rm[1] ? {4'd0, (rb > ra) ? rb - ra : ra - rb} :
                    rm[2] ? mul_nx :
                    rm[3] ? {4'd0, div_nx[3:0]} : 8'd0;
    end
    // double-dabble step: add 3 to each BCD nibble >= 5, then shift left
    always_comb begin
        sr_nx = sr;
        for (int i = 0; i < 3; i++)
            if (sr[8 + 4*i +: 4] >= 4'd5) sr_nx[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
        sr_nx = {sr_nx[18:0], 1'b0};
    end
    // sequencer: capture, execute, convert, publish registered result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            {ra, rb, rm, acc, res, sr, cnt, neg_r, err_r} <= '0;
            {busy, done, op, neg, err, bcd1, bcd2, bcd3} <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ra    <= a;
                    rb    <= b;
                    rm    <= mode;
                    acc   <= mode[3] ? {4'd0, a} : 8'd0;
                    cnt   <= 3'd0;
                    busy  <= 1'b1;
                    err_r <= bad;
                    neg_r <= 1'b0;
                    res   <= 8'd0;
                    sr    <= 20'd0;
                    state <= bad ? CONV : EXEC;
                end
                EXEC: begin
                    acc <= rm[2] ? mul_nx : div_nx;
                    cnt <= exec_last ? 3'd0 : cnt + 3'd1;
                    if (exec_last) begin
                        res   <= exec_res;
                        sr    <= {12'd0, exec_res};
                        neg_r <= rm[1] && (rb > ra);
                        state <= CONV;
                    end
                end
                CONV: begin
                    sr  <= sr_nx;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        done  <= 1'b1;
                        op    <= res;
                        neg   <= neg_r;
                        err   <= err_r;
                        {bcd3, bcd2, bcd1} <= sr_nx[19:8];
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: scoreboard bench with a plain-arithmetic reference model
module tb_calc_seq_ctrl;
    typedef struct packed {
        logic [7:0] op;
        logic       neg;
        logic       err;
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
    } res_t;

    logic       clk = 0, rst_n = 1, start = 0;
    logic [3:0] a = 0, b = 0, mode = 0;
    logic       busy, done, neg, err;
    logic [7:0] op;
    logic [3:0] bcd1, bcd2, bcd3;

    int   edge_n = 0, free_at = 0, act_lo = 1, act_hi = 0;
    int   checks = 0, errors = 0;
    res_t qr[$];
    int   qe[$];
    res_t last = '0;

    calc_seq_ctrl dut (
        .clk(clk), .reset(rst_n), .a(a), .b(b), .mode(mode), .start(start),
        .busy(busy), .done(done), .op(op), .neg(neg), .err(err),
        .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3)
    );

    always #5 clk = ~clk;

    function automatic logic is_err(input logic [3:0] bi, input logic [3:0] m);
        return !(m == 4'd1 || m == 4'd2 || m == 4'd4 || m == 4'd8) || (m == 4'd8 && bi == 4'd0);
    endfunction

    function automatic res_t ref_model(input logic [3:0] ai, input logic [3:0] bi, input logic [3:0] m);
        res_t e;
        int   x, y, r;
        e = '0;
        x = int'(ai);
        y = int'(bi);
        if (is_err(bi, m)) begin
            e.err = 1'b1;
            return e;
        end
        case (m)
            4'd1:    r = x + y;
            4'd2:    begin r = (y > x) ? y - x : x - y; e.neg = (y > x); end
            4'd4:    r = x * y;
            default: r = x / y;
        endcase
        e.op = r[7:0];
        e.d1 = 4'(r % 10);
        e.d2 = 4'((r / 10) % 10);
        e.d3 = 4'(r / 100);
        return e;
    endfunction

    function automatic int latency(input logic [3:0] bi, input logic [3:0] m);
        return is_err(bi, m) ? 9 : (m == 4'd1 || m == 4'd2) ? 10 : 13;
    endfunction

    // edge index: at a negedge it equals the number of rising edges seen so far
    always @(posedge clk) edge_n <= edge_n + 1;

    // reference model: decides which edges capture and what the result must be
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qr.delete();
            qe.delete();
            free_at <= 0;
            act_lo  <= 1;
            act_hi  <= 0;
        end else if (start && edge_n >= free_at) begin
            qr.push_back(ref_model(a, b, mode));
            qe.push_back(edge_n + latency(b, mode));
            free_at <= edge_n + latency(b, mode) + 1;
            act_lo  <= edge_n + 1;
            act_hi  <= edge_n + latency(b, mode);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // monitor: checks busy every cycle, pops the scoreboard on done, checks held outputs
    initial forever begin
        @(negedge clk);
        if (!rst_n) last = '0;
        chk("busy", 32'(busy), 32'(edge_n >= act_lo && edge_n <= act_hi));
        if (done) begin
            if (qe.size() == 0) chk("spurious_done", 32'(done), 32'd0);
            else begin
                last = qr.pop_front();
                chk("done_latency", 32'(edge_n), 32'(qe.pop_front()));
            end
        end else if (qe.size() > 0 && edge_n > qe[0]) begin
            chk("done_missing", 32'(done), 32'd1);
            void'(qr.pop_front());
            void'(qe.pop_front());
        end
        chk("result", 32'({op, neg, err, bcd3, bcd2, bcd1}), 32'(last));
    end

    // one request, a scrambled operand change and an ignored start pulse while busy
    task automatic run(input logic [3:0] ai, input logic [3:0] bi, input logic [3:0] mi);
        @(negedge clk);
        a = ai; b = bi; mode = mi; start = 1;
        @(negedge clk);
        start = 0; a = 4'($urandom); b = 4'($urandom); mode = 4'($urandom);
        repeat (2) @(negedge clk);
        start = 1; mode = 4'b0001;
        @(negedge clk);
        start = 0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        run(4'd9, 4'd7, 4'b0001);
        run(4'd3, 4'd9, 4'b0010);
        run(4'd9, 4'd3, 4'b0010);
        run(4'd15, 4'd15, 4'b0100);
        run(4'd13, 4'd4, 4'b1000);
        run(4'd5, 4'd0, 4'b1000);
        run(4'd7, 4'd2, 4'b0011);
        run(4'd0, 4'd0, 4'b0001);
        // start held high across several operations
        @(negedge clk);
        a = 4'd8; b = 4'd5; mode = 4'b0001; start = 1;
        repeat (30) @(negedge clk);
        start = 0;
        repeat (14) @(negedge clk);
        // reset in the middle of a multiply
        run(4'd12, 4'd11, 4'b0100);
        @(negedge clk);
        a = 4'd15; b = 4'd13; mode = 4'b0100; start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(posedge clk);
        #2 rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        run(4'd1, 4'd1, 4'b0001);
        // randomized traffic, mostly one-hot modes with occasional junk
        repeat (600) begin
            @(negedge clk);
            start = ($urandom % 3) == 0;
            a = 4'($urandom);
            b = 4'($urandom);
            mode = ($urandom % 8 == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        end
        start = 0;
        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Multi-cycle sequencer for the 4-bit calculator datapath. Accepts a one-hot operation request with a start/done handshake and runs add/subtract in one cycle, multiply as 4-step shift-add and divide as 4-step restoring division. It then performs binary-to-BCD conversion one bit per cycle and publishes the registered result. It sits between the switch/debounce front end and the 7-segment multiplexer, and replaces single-cycle combinational arithmetic and looped BCD conversion.

## Interface
- No parameters; widths fixed: operands 4 bits, result 8 bits, three BCD digits.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- a  in  4  operand A, unsigned
- b  in  4  operand B, unsigned
- mode  in  4  one-hot op select: 0001 add, 0010 sub, 0100 mul, 1000 div
- start  in  1  request; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the result is valid
- op  out  8  binary result magnitude
- neg  out  1  result negative (sub with b > a)
- err  out  1  divide by zero or non-one-hot mode
- bcd1  out  4  units digit of op
- bcd2  out  4  tens digit
- bcd3  out  4  hundreds digit

## Operation
- States: IDLE, EXEC, CONV, DONE.
- IDLE: on start=1, capture a, b and mode into internal registers. Go to EXEC, or to CONV with err_pending=1 and result 0 if mode is not one-hot or (mode=1000 and b=0).
- EXEC add: result = a+b, neg=0; 1 cycle.
- EXEC sub: if b>a, result = b-a and neg=1; else result = a-b and neg=0; 1 cycle.
- EXEC mul: 8-bit accumulator, 4 cycles. In step i, add a<<i if b[i]=1. 15*15=225 fits without overflow.
- EXEC div: restoring division, 4 cycles, MSB first. Result = {4'b0, quotient}; the remainder is discarded.
- CONV: double-dabble over a 20-bit shift register, exactly 8 cycles.
  - Each cycle: add 3 to every BCD nibble that is >= 5, then shift left by 1.
  - The 3-bit step counter wraps to 0 on exit.
- DONE: load op, neg, err and bcd1..3 from the internal registers. Assert done for this single cycle, then return to IDLE.
- Output registers hold their values until the next DONE. They are not cleared at start.
- start is ignored while busy=1; no queuing.
- mode/a/b changes after capture have no effect on the running operation.

## Timing
- Reset (asynchronous, active-low): state = IDLE. busy, done, op, neg, err, bcd1, bcd2, bcd3 all = 0. Internal counters = 0.
- Reset release: the first rising edge with reset=1 may accept start.
- Latency, counted from the capturing edge (edge 0) to the cycle in which done=1:
  - add/sub: 10 cycles (1 EXEC + 8 CONV + DONE)
  - mul/div: 13 cycles (4 EXEC + 8 CONV + DONE)
  - err path: 9 cycles (EXEC skipped)
- busy rises on the cycle after edge 0 and falls in the cycle after DONE. busy is high during the DONE cycle.
- start held continuously: a new operation is captured on the first edge in IDLE after DONE. Back-to-back throughput is 1 per 11 cycles for add.
- Reset asserted mid-EXEC or mid-CONV: immediate abort with no done pulse. Outputs go to 0.
- err=1 forces op=0, neg=0 and BCD digits 0.

## Test plan
- Add a=9, b=7, mode=0001, start pulse: done exactly 10 cycles after capture; op=16, neg=0, err=0, bcd3/2/1 = 0/1/6.
- Sub a=3, b=9, mode=0010: op=6, neg=1, BCD 0/0/6. Then sub a=9, b=3: op=6, neg=0.
- Mul a=15, b=15, mode=0100: done at 13 cycles; op=225, BCD 2/2/5. Changing a/b while busy does not alter the result.
- Div a=13, b=4, mode=1000: op=3, done at 13 cycles. Div a=5, b=0: err=1, op=0, done at 9 cycles. mode=0011: err=1.
- Start pulse while busy is ignored: exactly one done per accepted request. start held high for 30 cycles on add yields done at cycles 10 and 21.
- Reset low at cycle 6 of a mul: all outputs 0 asynchronously and no done pulse. After release, a new add 1+1 completes with op=2.
